// File: rtl/seq_right_shifter.sv
// Iterative one-bit-per-cycle right shifter (logical/arithmetic) with start/busy/done handshake.
// Optional ROTATE_EN macro adds a rotate-right mode selected by the `rotate` port.
module seq_right_shifter #(
   parameter int dataWidth  = 32,
   parameter int shamtWidth = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [dataWidth-1:0]  dataIn,
   input  logic [shamtWidth-1:0] shamt,
   input  logic                  arith,
`ifdef ROTATE_EN
   input  logic                  rotate,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [dataWidth-1:0]  rdataOut
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateT;

   stateT                 state;
   logic [dataWidth-1:0]  work;
   logic [shamtWidth-1:0] count;
   logic                  arithReg;
   logic                  fillBit;
   logic [dataWidth-1:0]  shifted;
`ifdef ROTATE_EN
   logic                  rotateReg;
`endif

   // Next one-bit shift of the working value; rotate overrides sign fill.
   always_comb begin
      fillBit = arithReg & work[dataWidth-1];
`ifdef ROTATE_EN
      if (rotateReg) fillBit = work[0];
`endif
      shifted = {fillBit, work[dataWidth-1:1]};
   end

   // Control FSM and datapath registers; start is ignored while shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         work     <= '0;
         count    <= '0;
         arithReg <= 1'b0;
         rdataOut <= '0;
`ifdef ROTATE_EN
         rotateReg <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  work     <= dataIn;
                  count    <= shamt;
                  arithReg <= arith;
`ifdef ROTATE_EN
                  rotateReg <= rotate;
`endif
                  if (shamt == '0) begin
                     rdataOut <= dataIn;
                     state    <= DONE;
                  end else begin
                     state <= SHIFT;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               work  <= shifted;
               count <= count - 1'b1;
               if (count == shamtWidth'(1)) begin
                  rdataOut <= shifted;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
